// File: rtl/cond_unit_it_pkg.sv
// Shared types for the conditional-execution unit: condition codes,
// NZCV bit positions and the IT-block sequencer states.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef enum logic {IT_IDLE, IT_ACTIVE} it_state_e;

endpackage

// File: rtl/cond_unit_it_if.sv
// Decoder-side bundle of the conditional-execution unit; the master drives
// requests, the slave (the unit) returns gated writes and status.
interface cond_unit_it_if #(
  parameter int MAX_IT = 4,
  parameter int NGRP   = 2
);
  localparam int LEN_W = $clog2(MAX_IT + 1);

  logic              InstrValid;
  logic [3:0]        Cond;
  logic [3:0]        ALUFlags;
  logic [NGRP-1:0]   FlagW;
  logic              PCS;
  logic              RegW;
  logic              MemW;
  logic              ITStart;
  logic [3:0]        ITCond;
  logic [LEN_W-1:0]  ITLen;
  logic [MAX_IT-1:0] ITPattern;
  logic              PCSrc;
  logic              RegWrite;
  logic              MemWrite;
  logic              CondEx;
  logic [3:0]        Flags;
  logic              InIT;
  logic              ITErr;

  modport master (
    output InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
           ITStart, ITCond, ITLen, ITPattern,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, InIT, ITErr
  );

  modport slave (
    input  InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
           ITStart, ITCond, ITLen, ITPattern,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, InIT, ITErr
  );

endinterface

// File: rtl/cond_unit_it_eval.sv
// Pure combinational ARM condition check: condition field + NZCV -> pass.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[N_IDX];
  assign w_z = i_flags[Z_IDX];
  assign w_c = i_flags[C_IDX];
  assign w_v = i_flags[V_IDX];

  always_comb begin
    o_pass = 1'b0;
    case (cond_e'(i_cond))
      EQ: o_pass = w_z;
      NE: o_pass = ~w_z;
      CS: o_pass = w_c;
      CC: o_pass = ~w_c;
      MI: o_pass = w_n;
      PL: o_pass = ~w_n;
      VS: o_pass = w_v;
      VC: o_pass = ~w_v;
      HI: o_pass = w_c & ~w_z;
      LS: o_pass = ~w_c | w_z;
      GE: o_pass = (w_n == w_v);
      LT: o_pass = (w_n != w_v);
      GT: o_pass = ~w_z & (w_n == w_v);
      LE: o_pass = w_z | (w_n != w_v);
      AL: o_pass = 1'b1;
      NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_it.sv
// Conditional-execution unit: NZCV register with group write enables,
// condition gating of PCSrc/RegWrite/MemWrite and an IT-block sequencer.
module cond_unit_it
  import cond_pkg::*;
#(
  parameter int MAX_IT = 4,
  parameter int NGRP   = 2
) (
  input logic        clk,
  input logic        reset,
  cond_unit_it_if.slave bus
);

  localparam int GRP_W = 4 / NGRP;
  localparam int LEN_W = $clog2(MAX_IT + 1);

  it_state_e         r_state, w_stateNext;
  logic [3:0]        r_flags, w_flagsNext;
  logic [3:0]        r_baseCond, w_baseCondNext;
  logic [MAX_IT-1:0] r_pat, w_patNext;
  logic [LEN_W-1:0]  r_remaining, w_remainingNext;
  logic [LEN_W-1:0]  r_idx, w_idxNext;
  logic              r_itErr, w_itErrNext;

  logic [MAX_IT-1:0] w_patShift;
  logic [3:0]        w_effCond;
  logic              w_pass;
  logic              w_condEx;
  logic              w_pcSrc;
  logic              w_itLenOk;

  assign w_patShift = r_pat >> r_idx;
  assign w_itLenOk  = (bus.ITLen != '0) && (bus.ITLen <= LEN_W'(MAX_IT));

  // Inside a block the low condition bit flips for "else" members; the IT
  // instruction itself always executes unconditionally.
  always_comb begin
    w_effCond = bus.Cond;
    if (r_state == IT_ACTIVE) begin
      w_effCond = {r_baseCond[3:1], r_baseCond[0] ^ ~w_patShift[0]};
    end else if (bus.ITStart) begin
      w_effCond = 4'(AL);
    end
  end

  cond_eval u_eval (
    .i_cond  (w_effCond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  assign w_condEx     = w_pass & bus.InstrValid & ~reset;
  assign w_pcSrc      = bus.PCS & w_condEx;
  assign bus.CondEx   = w_condEx;
  assign bus.PCSrc    = w_pcSrc;
  assign bus.RegWrite = bus.RegW & w_condEx;
  assign bus.MemWrite = bus.MemW & w_condEx;
  assign bus.Flags    = r_flags;
  assign bus.InIT     = (r_state == IT_ACTIVE);
  assign bus.ITErr    = r_itErr;

  always_comb begin
    w_flagsNext = r_flags;
    for (int g = 0; g < NGRP; g++) begin
      if (bus.FlagW[g] & w_condEx) begin
        w_flagsNext[g*GRP_W +: GRP_W] = bus.ALUFlags[g*GRP_W +: GRP_W];
      end
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_baseCondNext  = r_baseCond;
    w_patNext       = r_pat;
    w_remainingNext = r_remaining;
    w_idxNext       = r_idx;
    w_itErrNext     = 1'b0;
    case (r_state)
      IT_IDLE: begin
        if (bus.InstrValid & bus.ITStart) begin
          if (w_itLenOk) begin
            w_stateNext     = IT_ACTIVE;
            w_baseCondNext  = bus.ITCond;
            w_patNext       = bus.ITPattern | MAX_IT'(1);
            w_remainingNext = bus.ITLen;
            w_idxNext       = '0;
          end else begin
            w_itErrNext = 1'b1;
          end
        end
      end
      IT_ACTIVE: begin
        if (bus.InstrValid) begin
          w_itErrNext     = bus.ITStart;
          w_idxNext       = r_idx + LEN_W'(1);
          w_remainingNext = r_remaining - LEN_W'(1);
          // A taken branch leaves the block just like its last member does
          if (w_pcSrc || (r_remaining == LEN_W'(1))) begin
            w_stateNext     = IT_IDLE;
            w_idxNext       = '0;
            w_remainingNext = '0;
          end
        end
      end
      default: w_stateNext = IT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IT_IDLE;
      r_flags     <= '0;
      r_baseCond  <= '0;
      r_pat       <= '0;
      r_remaining <= '0;
      r_idx       <= '0;
      r_itErr     <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_flags     <= w_flagsNext;
      r_baseCond  <= w_baseCondNext;
      r_pat       <= w_patNext;
      r_remaining <= w_remainingNext;
      r_idx       <= w_idxNext;
      r_itErr     <= w_itErrNext;
    end
  end

endmodule

// File: tb/tb_cond_unit_it.sv
// Directed vector bench for cond_unit_it: each record is applied after a
// rising edge and every output is compared on the following falling edge.
module tb_cond_unit_it;
  import cond_pkg::*;

  localparam int MAX_IT = 4;
  localparam int NGRP   = 2;

  typedef struct {
    logic       rst, valid;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic       pcs, rw, mw, its;
    logic [3:0] itc;
    logic [2:0] itl;
    logic [3:0] itp;
    logic       cex, pc, rwr, mwr;
    logic [3:0] flags;
    logic       init, err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  vec_t resetSeq[$];

  always #5 clk = ~clk;

  cond_unit_it_if #(.MAX_IT(MAX_IT), .NGRP(NGRP)) bus ();

  cond_unit_it #(.MAX_IT(MAX_IT), .NGRP(NGRP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic vec_t mk(
    input logic rst, valid, input logic [3:0] cond, alu, input logic [1:0] fw,
    input logic pcs, rw, mw, its, input logic [3:0] itc, input logic [2:0] itl,
    input logic [3:0] itp, input logic cex, pc, rwr, mwr, input logic [3:0] flags,
    input logic init, err);
    vec_t v;
    v.rst = rst; v.valid = valid; v.cond = cond; v.alu = alu; v.fw = fw;
    v.pcs = pcs; v.rw = rw; v.mw = mw; v.its = its; v.itc = itc; v.itl = itl;
    v.itp = itp; v.cex = cex; v.pc = pc; v.rwr = rwr; v.mwr = mwr;
    v.flags = flags; v.init = init; v.err = err;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset          = v.rst;
    bus.InstrValid = v.valid;
    bus.Cond       = v.cond;
    bus.ALUFlags   = v.alu;
    bus.FlagW      = v.fw;
    bus.PCS        = v.pcs;
    bus.RegW       = v.rw;
    bus.MemW       = v.mw;
    bus.ITStart    = v.its;
    bus.ITCond     = v.itc;
    bus.ITLen      = v.itl;
    bus.ITPattern  = v.itp;
  endtask

  task automatic checkField(input string name, input int idx,
                            input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL vec%0d %s got %b want %b", idx, name, got, want);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    @(negedge clk);
    checkField("CondEx",   idx, {3'b0, bus.CondEx},   {3'b0, v.cex});
    checkField("PCSrc",    idx, {3'b0, bus.PCSrc},    {3'b0, v.pc});
    checkField("RegWrite", idx, {3'b0, bus.RegWrite}, {3'b0, v.rwr});
    checkField("MemWrite", idx, {3'b0, bus.MemWrite}, {3'b0, v.mwr});
    checkField("Flags",    idx, bus.Flags,            v.flags);
    checkField("InIT",     idx, {3'b0, bus.InIT},     {3'b0, v.init});
    checkField("ITErr",    idx, {3'b0, bus.ITErr},    {3'b0, v.err});
  endtask

  initial begin
    bus.InstrValid = 0; bus.Cond = 4'hE; bus.ALUFlags = 0; bus.FlagW = 0;
    bus.PCS = 0; bus.RegW = 0; bus.MemW = 0; bus.ITStart = 0;
    bus.ITCond = 0; bus.ITLen = 0; bus.ITPattern = 0;

    //               rst v cond  alu   fw    pcs rw mw its itc  itl   itp     cex pc rwr mwr flags init err
    vecs.push_back(mk(1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'hF, 4'h0, 2'b00, 1, 1, 1, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0));
    // split-group flag writes, then EQ sees Z=1
    vecs.push_back(mk(0, 1, 4'hE, 4'hF, 2'b10, 0, 0, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b01, 0, 0, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 0, 0, 4'b1100, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 0, 4'b1100, 0, 0));
    // failing condition blocks its own flag write
    vecs.push_back(mk(0, 1, 4'hE, 4'h1, 2'b11, 0, 0, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 0, 0, 4'b1100, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 4'h4, 2'b11, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h4, 2'b11, 0, 0, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 0, 0, 4'b0001, 0, 0));
    // IT EQ len 3 pattern then/else/then with Z=1
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd3, 4'b0101, 1, 0, 0, 0, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 1, 4'hF, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 4'hF, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 4'hF, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 1, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 1, 4'b0100, 0, 0));
    // len 4 with bit0 forced to then, two stall cycles after idx1
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd4, 4'b0100, 1, 0, 0, 0, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 1, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 0, 4'b0100, 0, 0));
    // taken branch at idx1 ends the block; next instruction uses its own Cond
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd4, 4'b0011, 1, 0, 0, 0, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 1, 0, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 0, 4'b0100, 0, 0));
    // zero-length IT is rejected with a one-cycle error pulse
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd0, 4'b1111, 1, 0, 0, 0, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 0, 0, 4'b0100, 0, 1));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 0, 0, 4'b0100, 0, 0));
    // nested ITStart is a plain member and flags an error
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd2, 4'b0001, 1, 0, 0, 0, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 1, 4'h0, 3'd3, 4'b0000, 1, 0, 1, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b0100, 1, 1));
    vecs.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 0, 0, 4'b0100, 0, 0));

    // reset asserted at idx2 of a block with non-zero flags
    resetSeq.push_back(mk(0, 1, 4'hE, 4'hA, 2'b11, 0, 0, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 0, 0, 4'b0100, 0, 0));
    resetSeq.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 4'h0, 3'd4, 4'b1111, 1, 0, 0, 0, 4'b1010, 0, 0));
    resetSeq.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b1010, 1, 0));
    resetSeq.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b1010, 1, 0));
    resetSeq.push_back(mk(1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 0, 4'b1010, 1, 0));
    resetSeq.push_back(mk(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 4'h0, 3'd0, 4'b0000, 1, 0, 1, 0, 4'b0000, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    for (int i = 0; i < resetSeq.size(); i++) begin
      applyStimulus(resetSeq[i]);
      checkOutput(resetSeq[i], 100 + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit_it.md
Name: cond_unit_it

Overview:
- Parametrised successor of the control unit's conditional-execution logic.
- Holds the NZCV flag register with per-group, condition-gated write enables.
- Evaluates the 4-bit condition field, and adds an IT-block sequencer: up to MAX_IT following instructions execute under a shared base condition with then/else polarity.
- Sits between the main decoder and the datapath write enables.
- Gates PCSrc, RegWrite and MemWrite per instruction.

Parameters:
- MAX_IT, 4, maximum IT-block length; must be 1..8.
- NGRP, 2, number of flag write groups; FlagW width; must divide 4.
- GRP_W, 4/NGRP, flags per group (derived, localparam). Group g covers Flags[(g+1)*GRP_W-1 : g*GRP_W].

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- InstrValid  in  1  an instruction is presented this cycle; state advances only when high
- Cond  in  4  instruction condition field (used outside IT blocks)
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  in  NGRP  per-group flag write request from the decoder
- PCS, RegW, MemW  in  1 each  unconditional write/branch requests from the decoder
- ITStart  in  1  current instruction is an IT instruction
- ITCond  in  4  IT base condition
- ITLen  in  $clog2(MAX_IT+1)  number of instructions covered, 1..MAX_IT
- ITPattern  in  MAX_IT  bit i=1: instruction i is "then"; bit i=0: instruction i is "else"; bit 0 is forced to "then"
- PCSrc, RegWrite, MemWrite  out  1 each  gated requests
- CondEx  out  1  current instruction's condition passed
- Flags  out  4  registered {N,Z,C,V}
- InIT  out  1  IT block active
- ITErr  out  1  one-cycle pulse on an illegal IT event

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - Flags=0, state IDLE, counter=0, InIT=0, ITErr=0.
  - While reset is high, PCSrc, RegWrite, MemWrite and CondEx are forced to 0.
- Effective condition (combinational):
  - In IDLE: EffCond=Cond.
  - In ACTIVE: EffCond={BaseCond[3:1], BaseCond[0] ^ ~Pat[idx]}. idx is the index of the current instruction within the block, 0-based.
- Condition evaluation uses the standard ARM table:
  - EQ NE CS CC MI PL VS VC HI LS GE LT GT LE
  - 1110 = always
  - 1111 = never (CondEx=0; never X)
  - GE means N==V.
- Output gating:
  - CondEx = eval(EffCond, Flags) & InstrValid.
  - PCSrc = PCS & CondEx; RegWrite = RegW & CondEx; MemWrite = MemW & CondEx.
  - All of these are combinational, with zero latency.
- Flag update, at the clock edge:
  - For each g: if FlagW[g] & CondEx, the group-g slice of Flags <= the group-g slice of ALUFlags.
  - The next instruction sees the new flags.
- State machine (IDLE / ACTIVE):
  - IDLE -> ACTIVE on InstrValid & ITStart & (1<=ITLen<=MAX_IT). Latch BaseCond=ITCond, Pat=ITPattern with bit 0 forced to 1, Remaining=ITLen, idx=0.
  - The IT instruction itself executes as AL. It produces no writes unless the decoder requests them.
  - ITStart with ITLen=0 or ITLen>MAX_IT: stay in IDLE, pulse ITErr.
  - ACTIVE: on each InstrValid, idx++ and Remaining--. When Remaining reaches 0, go to IDLE at that edge.
  - InstrValid low: hold all state (stall).
  - Taken branch inside the block (PCSrc=1): the block terminates, and the state is IDLE next cycle.
  - ITStart while ACTIVE: the instruction is evaluated as a normal block member (it is not restarted), ITErr pulses, and the block continues.
  - Reset mid-block: IDLE next cycle, with the flags cleared.
- InIT = (state==ACTIVE).

Decomposition:
- Package cond_pkg holds:
  - cond_e enum (EQ..AL, NV)
  - flag index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0
  - it_state_e {IT_IDLE, IT_ACTIVE}
- Sub-module cond_eval: a pure combinational condition/flags -> pass function, reused by the decoder tests.

Test Plan:
- Reset, then Cond=1110, RegW=1, InstrValid=1 -> RegWrite=1, Flags=0000, InIT=0. Cond=1111 -> CondEx=0.
- Flag write, split groups: FlagW=2'b10 with ALUFlags=1111, then FlagW=2'b01 with ALUFlags=0000 -> Flags=1100. Next instruction Cond=0000 (EQ) -> CondEx=1.
- Gated flag write: Flags Z=0, instruction Cond=EQ, FlagW=2'b11, ALUFlags=0100 -> no update; Flags unchanged.
- IT block: ITStart, ITCond=0000, ITLen=3, ITPattern=3'b101, with Z=1. Then three instructions with RegW=1 -> RegWrite sequence 1,0,1; InIT drops after the third instruction.
- Stall and early exit:
  - IT block of length 4 with InstrValid low for 2 cycles mid-block -> idx holds.
  - A taken branch at idx=1 -> InIT=0 next cycle; the following instruction uses Cond.
- Errors and reset:
  - ITStart with ITLen=0 -> ITErr pulses 1 cycle; state stays IDLE.
  - Reset asserted at idx=2 -> InIT=0 and Flags=0 next cycle.
